// File: rtl/seg7_scan_driver_if.sv
// Bus between a display controller and the multiplexed 7-segment scan driver.
// value/dp_in/load/enable flow toward the driver; the pin-level outputs flow back.
interface seg7_scan_driver_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   dp_in;
  logic                load;
  logic                enable;
  logic [6:0]          seg;
  logic                dp;
  logic [DIGITS-1:0]   an;
  logic                frame_done;

  modport master (
    output value, dp_in, load, enable,
    input  seg, dp, an, frame_done
  );

  modport slave (
    input  value, dp_in, load, enable,
    output seg, dp, an, frame_done
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex 7-segment driver: prescaled digit scan, tear-free
// frame update of display data, optional leading-zero blanking and pin polarity.
module seg7_scan_driver #(
  parameter int DIGITS     = 4,
  parameter int CLK_DIV    = 50000,
  parameter int ACTIVE_LOW = 1,
  parameter int LZ_BLANK   = 0
) (
  input logic               clk,
  input logic               rst,
  seg7_scan_driver_if.slave bus
);
  localparam int              PW   = $clog2(CLK_DIV);
  localparam int              IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0]   PMAX = PW'(CLK_DIV - 1);
  localparam logic [IW-1:0]   IMAX = IW'(DIGITS - 1);
  localparam logic            POL  = (ACTIVE_LOW != 0);

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
    endcase
    return s;
  endfunction

  logic [PW-1:0]       presc;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] pend_val, act_val;
  logic [DIGITS-1:0]   pend_dp, act_dp;
  logic [6:0]          seg_q;
  logic                dp_q;
  logic [DIGITS-1:0]   an_q;
  logic                fd_q;

  logic                tick, wrap;
  logic [IW-1:0]       idx_nxt;
  logic [4*DIGITS-1:0] val_nxt;
  logic [DIGITS-1:0]   dp_nxt;
  logic [DIGITS-1:0]   upz;
  logic [3:0]          nib;
  logic                dsel, blank;
  logic [DIGITS-1:0]   an_sel;
  logic [6:0]          seg_raw;
  logic                dp_raw;
  logic [DIGITS-1:0]   an_raw;

  // Next-state view: outputs are decoded from the index and data that will be
  // current after this edge, which gives the one-cycle tick-to-pin latency.
  always_comb begin
    tick    = bus.enable && (presc == PMAX);
    wrap    = tick && (idx == IMAX);
    idx_nxt = idx;
    if (wrap)      idx_nxt = '0;
    else if (tick) idx_nxt = idx + 1'b1;
    val_nxt = act_val;
    dp_nxt  = act_dp;
    if (wrap) begin
      val_nxt = bus.load ? bus.value : pend_val;
      dp_nxt  = bus.load ? bus.dp_in : pend_dp;
    end
  end

  // upz[g]: nibble g and every more significant nibble are zero
  for (genvar g = 0; g < DIGITS; g++) begin : g_upz
    assign upz[g] = ~|val_nxt[4*DIGITS-1:4*g];
  end

  always_comb begin
    nib    = '0;
    dsel   = 1'b0;
    blank  = 1'b0;
    an_sel = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_nxt == IW'(i)) begin
        nib       = val_nxt[4*i +: 4];
        dsel      = dp_nxt[i];
        blank     = (LZ_BLANK != 0) && (i != 0) && upz[i];
        an_sel[i] = 1'b1;
      end
    end
    seg_raw = (bus.enable && !blank) ? hex7(nib) : 7'h00;
    dp_raw  = bus.enable && dsel;
    an_raw  = bus.enable ? an_sel : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc    <= '0;
      idx      <= '0;
      pend_val <= '0;
      pend_dp  <= '0;
      act_val  <= '0;
      act_dp   <= '0;
      seg_q    <= {7{POL}};
      dp_q     <= POL;
      an_q     <= {DIGITS{POL}};
      fd_q     <= 1'b0;
    end else begin
      if (bus.load) begin
        pend_val <= bus.value;
        pend_dp  <= bus.dp_in;
      end
      act_val <= val_nxt;
      act_dp  <= dp_nxt;
      if (bus.enable) presc <= tick ? '0 : presc + 1'b1;
      idx   <= idx_nxt;
      seg_q <= seg_raw ^ {7{POL}};
      dp_q  <= dp_raw ^ POL;
      an_q  <= an_raw ^ {DIGITS{POL}};
      fd_q  <= wrap;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.an         = an_q;
  assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: three instances cover the base
// configuration, leading-zero blanking and active-low pins.
module tb_seg7_scan_driver;
  logic clk = 1'b0;
  logic rst_a, rst_l, rst_h;
  int   nchk = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  seg7_scan_driver_if #(.DIGITS(4)) ia ();
  seg7_scan_driver_if #(.DIGITS(4)) il ();
  seg7_scan_driver_if #(.DIGITS(4)) ih ();

  seg7_scan_driver #(.DIGITS(4), .CLK_DIV(4), .ACTIVE_LOW(0), .LZ_BLANK(0))
    u_a (.clk(clk), .rst(rst_a), .bus(ia));
  seg7_scan_driver #(.DIGITS(4), .CLK_DIV(4), .ACTIVE_LOW(0), .LZ_BLANK(1))
    u_l (.clk(clk), .rst(rst_l), .bus(il));
  seg7_scan_driver #(.DIGITS(4), .CLK_DIV(4), .ACTIVE_LOW(1), .LZ_BLANK(0))
    u_h (.clk(clk), .rst(rst_h), .bus(ih));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int fd_cnt;

  initial begin
    rst_a = 1'b1; rst_l = 1'b1; rst_h = 1'b1;
    ia.value = '0; ia.dp_in = '0; ia.load = 1'b0; ia.enable = 1'b1;
    il.value = '0; il.dp_in = '0; il.load = 1'b0; il.enable = 1'b1;
    ih.value = '0; ih.dp_in = '0; ih.load = 1'b0; ih.enable = 1'b1;

    // base config: reset, scan order, frame pulse
    cyc(1);
    chk("a_rst_an",  ia.an, 4'h0);
    chk("a_rst_seg", ia.seg, 7'h00);
    chk("a_rst_dp",  ia.dp, 1'b0);
    chk("a_rst_fd",  ia.frame_done, 1'b0);
    cyc(2);
    rst_a = 1'b0;
    cyc(1);                                   // E0
    chk("a_e0_an",  ia.an, 4'b0001);
    chk("a_e0_seg", ia.seg, 7'h3F);
    chk("a_e0_fd",  ia.frame_done, 1'b0);
    cyc(2);                                   // E2
    chk("a_e2_an",  ia.an, 4'b0001);
    cyc(1);                                   // E3
    chk("a_e3_an",  ia.an, 4'b0010);
    chk("a_e3_seg", ia.seg, 7'h3F);
    cyc(4);                                   // E7
    chk("a_e7_an",  ia.an, 4'b0100);
    cyc(4);                                   // E11
    chk("a_e11_an", ia.an, 4'b1000);
    cyc(3);                                   // E14
    chk("a_e14_fd", ia.frame_done, 1'b0);
    cyc(1);                                   // E15
    chk("a_e15_an", ia.an, 4'b0001);
    chk("a_e15_fd", ia.frame_done, 1'b1);
    cyc(1);                                   // E16
    chk("a_e16_fd", ia.frame_done, 1'b0);
    fd_cnt = 0;
    for (int k = 0; k < 32; k++) begin        // E17..E48
      cyc(1);
      if (ia.frame_done) fd_cnt++;
    end
    chk("a_fd_per_16", fd_cnt, 2);

    // pending load mid-frame, committed at the next wrap
    cyc(8);                                   // E56, digit 2 slot
    ia.value = 16'h12AF; ia.load = 1'b1;
    cyc(1);                                   // E57
    ia.value = 16'h0000; ia.load = 1'b0;
    chk("a_ld_d2_an",  ia.an, 4'b0100);
    chk("a_ld_d2_seg", ia.seg, 7'h3F);
    cyc(2);                                   // E59
    chk("a_ld_d3_an",  ia.an, 4'b1000);
    chk("a_ld_d3_seg", ia.seg, 7'h3F);
    cyc(4);                                   // E63
    chk("a_new_d0_an",  ia.an, 4'b0001);
    chk("a_new_d0_seg", ia.seg, 7'h71);
    chk("a_new_fd",     ia.frame_done, 1'b1);
    cyc(4);                                   // E67
    chk("a_new_d1_seg", ia.seg, 7'h77);
    cyc(4);                                   // E71
    chk("a_new_d2_seg", ia.seg, 7'h5B);
    cyc(4);                                   // E75
    chk("a_new_d3_an",  ia.an, 4'b1000);
    chk("a_new_d3_seg", ia.seg, 7'h06);
    cyc(4);                                   // E79
    chk("a_hold_d0_seg", ia.seg, 7'h71);

    // load coincident with the wrap tick bypasses to active
    cyc(15);                                  // E94
    ia.value = 16'h0009; ia.dp_in = 4'b0100; ia.load = 1'b1;
    cyc(1);                                   // E95
    ia.value = 16'h0000; ia.dp_in = 4'b0000; ia.load = 1'b0;
    chk("a_byp_an",  ia.an, 4'b0001);
    chk("a_byp_seg", ia.seg, 7'h6F);
    chk("a_byp_dp",  ia.dp, 1'b0);
    cyc(4);                                   // E99
    chk("a_byp_d1_seg", ia.seg, 7'h3F);
    cyc(4);                                   // E103
    chk("a_dp_d2_an", ia.an, 4'b0100);
    chk("a_dp_d2_dp", ia.dp, 1'b1);

    // enable drop mid-slot, then resume
    cyc(1);                                   // E104
    ia.enable = 1'b0;
    cyc(1);                                   // E105
    chk("a_off_an",  ia.an, 4'b0000);
    chk("a_off_seg", ia.seg, 7'h00);
    chk("a_off_dp",  ia.dp, 1'b0);
    chk("a_off_fd",  ia.frame_done, 1'b0);
    cyc(9);                                   // E114
    chk("a_off_an2", ia.an, 4'b0000);
    ia.enable = 1'b1;
    cyc(1);                                   // E115
    chk("a_on_an",  ia.an, 4'b0100);
    chk("a_on_seg", ia.seg, 7'h3F);
    chk("a_on_dp",  ia.dp, 1'b1);
    cyc(1);                                   // E116
    chk("a_on_hold_an", ia.an, 4'b0100);
    cyc(1);                                   // E117
    chk("a_on_next_an", ia.an, 4'b1000);

    // leading-zero blanking; load during reset must be ignored
    il.value = 16'h0050; il.dp_in = 4'b1000; il.load = 1'b1;
    cyc(2);
    rst_l = 1'b0; il.load = 1'b0;
    cyc(1);                                   // E0
    chk("l_e0_seg", il.seg, 7'h3F);
    cyc(3);                                   // E3
    chk("l_e3_an",  il.an, 4'b0010);
    chk("l_e3_seg", il.seg, 7'h00);
    cyc(12);                                  // E15
    chk("l_e15_seg", il.seg, 7'h3F);
    cyc(4);                                   // E19
    chk("l_rstld_seg", il.seg, 7'h00);
    cyc(1);                                   // E20
    il.load = 1'b1;
    cyc(1);                                   // E21
    il.load = 1'b0; il.value = '0; il.dp_in = '0;
    cyc(10);                                  // E31
    chk("l_d0_an",  il.an, 4'b0001);
    chk("l_d0_seg", il.seg, 7'h3F);
    cyc(4);                                   // E35
    chk("l_d1_seg", il.seg, 7'h6D);
    cyc(4);                                   // E39
    chk("l_d2_seg", il.seg, 7'h00);
    cyc(4);                                   // E43
    chk("l_d3_an",  il.an, 4'b1000);
    chk("l_d3_seg", il.seg, 7'h00);
    chk("l_d3_dp",  il.dp, 1'b1);

    // active-low pins with reset mid-frame
    cyc(1);
    chk("h_rst_seg", ih.seg, 7'h7F);
    chk("h_rst_an",  ih.an, 4'hF);
    chk("h_rst_dp",  ih.dp, 1'b1);
    rst_h = 1'b0;
    cyc(1);                                   // E0
    chk("h_e0_an",  ih.an, 4'b1110);
    chk("h_e0_seg", ih.seg, 7'h40);
    chk("h_e0_dp",  ih.dp, 1'b1);
    cyc(6);                                   // E6, digit 1 slot
    rst_h = 1'b1;
    cyc(1);
    chk("h_mid_seg", ih.seg, 7'h7F);
    chk("h_mid_an",  ih.an, 4'hF);
    chk("h_mid_dp",  ih.dp, 1'b1);
    chk("h_mid_fd",  ih.frame_done, 1'b0);
    cyc(1);
    rst_h = 1'b0; ih.dp_in = 4'b0010; ih.load = 1'b1;
    cyc(1);                                   // E0'
    ih.dp_in = 4'b0000; ih.load = 1'b0;
    chk("h_re_an",  ih.an, 4'b1110);
    chk("h_re_seg", ih.seg, 7'h40);
    chk("h_re_fd",  ih.frame_done, 1'b0);
    cyc(3);                                   // E3'
    chk("h_old_d1_an", ih.an, 4'b1101);
    chk("h_old_d1_dp", ih.dp, 1'b1);
    cyc(12);                                  // E15'
    chk("h_wrap_an", ih.an, 4'b1110);
    chk("h_wrap_fd", ih.frame_done, 1'b1);
    cyc(4);                                   // E19'
    chk("h_d1_an",  ih.an, 4'b1101);
    chk("h_d1_dp",  ih.dp, 1'b0);
    chk("h_d1_seg", ih.seg, 7'h40);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter DIGITS, default 4, number of multiplexed digits (legal range 1..8).
REQ-002 Parameter CLK_DIV, default 50000, clk cycles per digit slot (minimum 2).
REQ-003 Parameter ACTIVE_LOW, default 1; 1 inverts seg, dp and an at the pins.
REQ-004 Parameter LZ_BLANK, default 0; 1 enables leading-zero blanking.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 value  input  4*DIGITS  hex nibbles; nibble i drives digit i; digit 0 is least significant.
REQ-008 dp_in  input  DIGITS  decimal-point request per digit.
REQ-009 load  input  1  one-cycle strobe; captures value and dp_in into the pending register.
REQ-010 enable  input  1  1 = scanning; 0 = display dark, scan frozen.
REQ-011 seg  output  7  segments {g,f,e,d,c,b,a}, registered.
REQ-012 dp  output  1  decimal-point segment, registered.
REQ-013 an  output  DIGITS  digit select, one-hot when lit, registered.
REQ-014 frame_done  output  1  one-cycle pulse at the end of each full scan frame.

Function
REQ-015 The prescaler SHALL count 0..CLK_DIV-1 and wrap; tick SHALL be asserted in the cycle where prescaler = CLK_DIV-1 and enable = 1.
REQ-016 On tick, the digit index SHALL advance 0,1,...,DIGITS-1, then wrap to 0; with DIGITS=1 it stays at 0.
REQ-017 seg, dp and an SHALL reflect the new index in the cycle after tick (1-cycle latency); between ticks they SHALL hold.
REQ-018 load SHALL write the pending register in the same edge; a later load overwrites an earlier one; load is accepted regardless of enable.
REQ-019 The pending register SHALL copy to the active register only on the tick where the index wraps DIGITS-1 -> 0 (tear-free frame update); the digit-0 slot of that frame SHALL already use the new active data.
REQ-020 If load and the wrap tick coincide, the active register SHALL take the value presented with load in that cycle (load bypasses to active).
REQ-021 frame_done SHALL pulse for exactly one cycle, in the cycle after the wrap tick, coincident with digit 0 appearing on an.
REQ-022 Decoding (active-high, before polarity), hex 0..F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
REQ-023 With LZ_BLANK=1, digit i>0 SHALL be blanked (seg all off, dp per dp_in) when its nibble and all higher nibbles are 0; digit 0 is never blanked.
REQ-024 dp SHALL equal the active dp bit for the selected digit.
REQ-025 When enable = 0, prescaler and index SHALL hold; in the next cycle an, seg and dp SHALL go inactive, and frame_done SHALL be 0.
REQ-026 When enable returns to 1, the current digit SHALL be redisplayed in the next cycle and scanning SHALL resume from the held prescaler count.
REQ-027 Inactive level: logic 0 when ACTIVE_LOW=0 and logic 1 when ACTIVE_LOW=1, for every bit of seg, dp and an.

Reset
REQ-028 rst SHALL clear the prescaler, index, pending and active registers to 0; seg, dp and an SHALL be at the inactive level and frame_done 0 from the first edge with rst high.
REQ-029 rst SHALL take priority over load, enable and tick in the same cycle; reset mid-frame SHALL abandon the frame and restart at digit 0 with prescaler 0, without asserting frame_done.
REQ-030 Digit 0 (all-zero data, seg=3F) SHALL be displayed in the first cycle after rst deasserts with enable=1.

Verification (DIGITS=4, CLK_DIV=4, ACTIVE_LOW=0, LZ_BLANK=0 unless stated)
REQ-031 Apply rst, release with enable=1 -> an=0001, seg=3F; an steps 0010, 0100, 1000, 0001 every 4 cycles; frame_done pulses once per 16 cycles.
REQ-032 load value=0x12AF mid-frame -> the current frame still shows 0000; from the next digit-0 slot: F->71, A->77, 2->5B, 1->06.
REQ-033 Assert load with value=0x0009 on the wrap tick -> the next digit-0 slot shows seg=6F, not the previous data.
REQ-034 LZ_BLANK=1, value=0x0050 -> digits 3,2 have seg=00; digit 1=6D; digit 0=3F.
REQ-035 Drop enable for 10 cycles mid-slot -> an=0000, seg=00 from the next cycle; after re-enable, the same digit resumes and the slot completes its remaining prescaler counts.
REQ-036 ACTIVE_LOW=1, dp_in=0010, rst mid-frame -> all outputs read 1 during reset; after release, digit 1 shows dp=0 (lit) and an=1101.
